// File: rtl/key_led_pkg.sv
// Shared constants for the key/LED bank: mode encodings, key polarity and
// default debounce / long-press thresholds.
package key_led_pkg;

    localparam logic MODE_FOLLOW = 1'b0;
    localparam logic MODE_TOGGLE = 1'b1;
    localparam logic KEY_PRESSED = 1'b0;

    localparam int CNT_MAX_DEF  = 999_999;
    localparam int LONG_MAX_DEF = 49_999_999;

    // Counter width able to hold 0..max, never narrower than one bit.
    function automatic int cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key channel: 2-flop synchroniser, debounce counter, press pulse and,
// with KEY_LED_BANK_LONG_PRESS_EN defined, a long-press counter.
module key_debounce
    import key_led_pkg::*;
#(
    parameter int CNT_MAX  = CNT_MAX_DEF,
    parameter int LONG_MAX = LONG_MAX_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic stable_nxt,
    output logic press_evt,
    output logic long_evt,
    output logic key_flag,
    output logic key_long
);

    localparam int CW = cnt_width(CNT_MAX);
    localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          expire;

    // A disagreement that survives CNT_MAX+1 samples is accepted this edge.
    assign expire     = (sync2 != stable) && (cnt == CNT_TOP);
    assign stable_nxt = expire ? sync2 : stable;
    assign press_evt  = expire && (sync2 == KEY_PRESSED);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            stable   <= 1'b1;
            cnt      <= '0;
            key_flag <= 1'b0;
        end else begin
            sync1    <= key_in;
            sync2    <= sync1;
            stable   <= stable_nxt;
            key_flag <= press_evt;
            if ((sync2 == stable) || expire) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef KEY_LED_BANK_LONG_PRESS_EN
    localparam int LW = cnt_width(LONG_MAX);
    localparam logic [LW-1:0] LONG_TOP = LW'(LONG_MAX);

    logic [LW-1:0] lp_cnt;

    // Fires on the edge lp_cnt reaches LONG_MAX; saturation keeps it single.
    assign long_evt = (stable == KEY_PRESSED) && (lp_cnt == LONG_TOP - 1'b1);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            lp_cnt   <= '0;
            key_long <= 1'b0;
        end else begin
            key_long <= long_evt;
            if (stable != KEY_PRESSED) begin
                lp_cnt <= '0;
            end else if (lp_cnt != LONG_TOP) begin
                lp_cnt <= lp_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_long_max;
    assign unused_long_max = |LONG_MAX;
    assign long_evt = 1'b0;
    assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_led_bank.sv
// Multi-channel key-to-LED controller with per-channel follow/toggle mode.
// Long-press support is enabled with KEY_LED_BANK_LONG_PRESS_EN.
module key_led_bank
    import key_led_pkg::*;
#(
    parameter int CH_NUM   = 4,
    parameter int CNT_MAX  = CNT_MAX_DEF,
    parameter int LONG_MAX = LONG_MAX_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [CH_NUM-1:0] key_in,
    input  logic [CH_NUM-1:0] mode_sel,
    output logic [CH_NUM-1:0] led_out,
    output logic [CH_NUM-1:0] key_flag,
    output logic [CH_NUM-1:0] key_long
);

    logic [CH_NUM-1:0] stable_nxt;
    logic [CH_NUM-1:0] press_evt;
    logic [CH_NUM-1:0] long_evt;
    logic [CH_NUM-1:0] mode_q;
    logic [CH_NUM-1:0] led_nxt;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        key_debounce #(
            .CNT_MAX  (CNT_MAX),
            .LONG_MAX (LONG_MAX)
        ) u_deb (
            .sys_clk    (sys_clk),
            .sys_rst    (sys_rst),
            .key_in     (key_in[g]),
            .stable_nxt (stable_nxt[g]),
            .press_evt  (press_evt[g]),
            .long_evt   (long_evt[g]),
            .key_flag   (key_flag[g]),
            .key_long   (key_long[g])
        );
    end

    // The registered mode makes a mode switch take effect one edge later.
    always_comb begin
        led_nxt = led_out;
        for (int i = 0; i < CH_NUM; i++) begin
            if (mode_q[i] == MODE_FOLLOW) begin
                led_nxt[i] = ~stable_nxt[i];
            end else if (long_evt[i]) begin
                led_nxt[i] = 1'b0;
            end else if (press_evt[i]) begin
                led_nxt[i] = ~led_out[i];
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mode_q  <= {CH_NUM{MODE_FOLLOW}};
            led_out <= '0;
        end else begin
            mode_q  <= mode_sel;
            led_out <= led_nxt;
        end
    end

endmodule

// File: tb/tb_key_led_bank.sv
// Directed self-checking bench for key_led_bank (CH_NUM=4, CNT_MAX=4,
// LONG_MAX=10); honours KEY_LED_BANK_LONG_PRESS_EN when defined.
module tb_key_led_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_in;
    logic [3:0] mode_sel;
    logic [3:0] led_out;
    logic [3:0] key_flag;
    logic [3:0] key_long;

    logic [3:0] flag_or;
    logic [3:0] long_or;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    key_led_bank #(
        .CH_NUM   (4),
        .CNT_MAX  (4),
        .LONG_MAX (10)
    ) dut (
        .sys_clk  (clk),
        .sys_rst  (rst),
        .key_in   (key_in),
        .mode_sel (mode_sel),
        .led_out  (led_out),
        .key_flag (key_flag),
        .key_long (key_long)
    );

    task automatic check(input string tag, input logic [3:0] got,
                         input logic [3:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        else
            n_pass++;
    endtask

    // Advance n cycles, ORing pulse outputs seen after each edge.
    task automatic run(input int n);
        flag_or = '0;
        long_or = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            flag_or |= key_flag;
            long_or |= key_long;
        end
    endtask

    task automatic toggle_press(input string tag, input logic [3:0] exp_led);
        key_in = 4'b1011;
        run(10);
        check({tag, "_flag"}, flag_or, 4'b0100);
        check({tag, "_led"}, led_out, exp_led);
        key_in = 4'b1111;
        run(10);
        check({tag, "_rel_led"}, led_out, exp_led);
    endtask

    initial begin
        rst      = 1'b1;
        key_in   = 4'b1111;
        mode_sel = 4'b0000;
        run(3);
        check("rst_led", led_out, 4'b0000);
        check("rst_flag", key_flag, 4'b0000);
        check("rst_long", key_long, 4'b0000);
        rst = 1'b0;
        run(10);
        check("idle_flag", flag_or, 4'b0000);
        check("idle_long", long_or, 4'b0000);
        check("idle_led", led_out, 4'b0000);

        // Clean press in follow mode on ch0
        key_in = 4'b1110;
        run(6);
        check("p0_e6_flag", key_flag, 4'b0000);
        check("p0_e6_led", led_out, 4'b0000);
        run(1);
        check("p0_e7_flag", key_flag, 4'b0001);
        check("p0_e7_led", led_out, 4'b0001);
        run(1);
        check("p0_e8_flag", key_flag, 4'b0000);
        run(4);
        key_in = 4'b1111;
        run(6);
        check("r0_e6_led", led_out, 4'b0001);
        run(1);
        check("r0_e7_led", led_out, 4'b0000);
        check("r0_flag", flag_or | key_flag, 4'b0000);

        // Bounce on ch1: low runs of 2 cycles never survive
        begin
            logic [3:0] acc = '0;
            for (int i = 0; i < 5; i++) begin
                key_in = 4'b1101;
                run(2);
                acc |= flag_or;
                key_in = 4'b1111;
                run(2);
                acc |= flag_or;
            end
            run(10);
            acc |= flag_or;
            check("bnc_flag", acc, 4'b0000);
            check("bnc_led", led_out, 4'b0000);
        end

        // Toggle mode on ch2
        mode_sel = 4'b0100;
        run(2);
        toggle_press("tg1", 4'b0100);
        toggle_press("tg2", 4'b0000);
        toggle_press("tg3", 4'b0100);
        mode_sel = 4'b0000;
        run(1);
        check("sw_e1_led", led_out, 4'b0100);
        run(1);
        check("sw_e2_led", led_out, 4'b0000);

        // Simultaneous presses on ch0 and ch3
        key_in = 4'b0110;
        run(6);
        check("sim_e6_flag", key_flag, 4'b0000);
        run(1);
        check("sim_e7_flag", key_flag, 4'b1001);
        check("sim_e7_led", led_out, 4'b1001);
        run(1);
        check("sim_e8_flag", key_flag, 4'b0000);
        key_in = 4'b1111;
        run(10);
        check("sim_rel_led", led_out, 4'b0000);

        // Reset mid-debounce on ch1, key held through deassertion
        key_in = 4'b1101;
        run(4);
        rst = 1'b1;
        run(2);
        check("mrst_led", led_out, 4'b0000);
        check("mrst_flag", flag_or, 4'b0000);
        rst = 1'b0;
        run(6);
        check("mrst_e6_flag", flag_or, 4'b0000);
        check("mrst_e6_led", led_out, 4'b0000);
        run(1);
        check("mrst_e7_flag", key_flag, 4'b0010);
        check("mrst_e7_led", led_out, 4'b0010);
        key_in = 4'b1111;
        run(10);
        check("mrst_rel_led", led_out, 4'b0000);

        // Long press on ch2 in toggle mode
        mode_sel = 4'b0100;
        run(2);
        key_in = 4'b1011;
        run(7);
        check("lp_e7_flag", key_flag, 4'b0100);
        check("lp_e7_led", led_out, 4'b0100);
        run(9);
        check("lp_e16_long", long_or, 4'b0000);
        check("lp_e16_led", led_out, 4'b0100);
        run(1);
`ifdef KEY_LED_BANK_LONG_PRESS_EN
        check("lp_e17_long", key_long, 4'b0100);
        check("lp_e17_led", led_out, 4'b0000);
`else
        check("lp_e17_long", key_long, 4'b0000);
        check("lp_e17_led", led_out, 4'b0100);
`endif
        run(3);
        check("lp_after_long", long_or, 4'b0000);
        key_in = 4'b1111;
        run(12);
        check("lp_rel_long", long_or, 4'b0000);
        check("lp_rel_flag", flag_or, 4'b0000);
`ifdef KEY_LED_BANK_LONG_PRESS_EN
        check("lp_rel_led", led_out, 4'b0000);
`else
        check("lp_rel_led", led_out, 4'b0100);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
